// File: rtl/arith_div_restoring_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle,
// valid/ready on both sides, one operation in flight at a time.
package arith_div_restoring_seq_pkg;

    function automatic int get_latency(input int op_w, input int in_pipe);
        return op_w + in_pipe;
    endfunction

endpackage

module arith_div_restoring_seq #(
    parameter int OP_W    = 32,
    parameter int IN_PIPE = 1
) (
    input  logic            clk,
    input  logic            a_rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [OP_W-1:0] out_q,
    output logic [OP_W-1:0] out_r,
    output logic            out_div0
);

    localparam int CW = (OP_W > 2) ? $clog2(OP_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OP_W-1:0] a_reg;
    logic [OP_W-1:0] b_reg;
    logic [OP_W-1:0] rem;
    logic [CW-1:0]   cnt;
    logic            div0;

    logic [OP_W:0]   sh;
    logic [OP_W:0]   t;
    logic            qbit;
    logic [OP_W-1:0] rem_nxt;
    logic [OP_W-1:0] quo_nxt;
    logic            accept;
    logic            last;

    // Ready is forced low while reset is held, not just after the edge.
    assign in_rdy  = a_rst_n && (state == S_IDLE);
    assign out_vld = (state == S_DONE);
    assign accept  = in_vld && in_rdy;
    assign last    = (cnt == '0);

    // Rem MSB stays in the shift so the trial subtract is exact.
    assign sh      = {rem, a_reg[OP_W-1]};
    assign t       = sh - {1'b0, b_reg};
    assign qbit    = ~t[OP_W];
    assign rem_nxt = qbit ? t[OP_W-1:0] : sh[OP_W-1:0];
    assign quo_nxt = {a_reg[OP_W-2:0], qbit};

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (IN_PIPE != 0) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: state_nxt = S_RUN;
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            rem      <= '0;
            cnt      <= '0;
            div0     <= 1'b0;
            out_q    <= '0;
            out_r    <= '0;
            out_div0 <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        out_div0 <= 1'b0;
                        if (IN_PIPE == 0) begin
                            rem  <= '0;
                            cnt  <= CW'(OP_W - 1);
                            div0 <= (in_b == '0);
                        end
                    end
                end
                S_LOAD: begin
                    rem  <= '0;
                    cnt  <= CW'(OP_W - 1);
                    div0 <= (b_reg == '0);
                end
                S_RUN: begin
                    rem   <= rem_nxt;
                    a_reg <= quo_nxt;
                    cnt   <= cnt - 1'b1;
                    if (last) begin
                        out_q    <= quo_nxt;
                        out_r    <= rem_nxt;
                        out_div0 <= div0;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
